// File: rtl/trisbus_arbiter.sv
// Round-robin arbiter for the Enable lines of N trisbuf drivers sharing one
// tristate bus. Each tenure is bounded by MAX_HOLD cycles (0 = unlimited), and
// between two owners all Enables stay low for TURN_CYCLES cycles.
module trisbus_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned MAX_HOLD    = 8,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [N-1:0]         Req,
  output logic [N-1:0]         Enable,
  output logic [$clog2(N)-1:0] Owner,
  output logic                 BusIdle
);

  localparam int unsigned OW = $clog2(N);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1) + 1;
  localparam int unsigned TW = $clog2(TURN_CYCLES + 1) + 1;
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [TW-1:0] TURN_LIM = TW'(TURN_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  state_t        state;
  logic [OW-1:0] ptr;
  logic [HW-1:0] hold;
  logic [TW-1:0] turn;

  logic          found;
  logic [OW-1:0] pick;
  logic          release_now;
  logic [OW-1:0] next_ptr;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    int unsigned j;
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = (32'(ptr) + i) % N;
      if (!found && Req[j]) begin
        found = 1'b1;
        pick  = j[OW-1:0];
      end
    end
  end

  // Current owner gives up the bus on request drop or when the hold limit is hit.
  always_comb begin
    release_now = !Req[Owner] || ((MAX_HOLD != 0) && (hold == HOLD_LIM));
    next_ptr    = (Owner == OW'(N - 1)) ? '0 : Owner + 1'b1;
  end

  // Arbitration FSM with registered Enable/Owner/BusIdle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      Enable  <= '0;
      Owner   <= '0;
      BusIdle <= 1'b1;
      ptr     <= '0;
      hold    <= '0;
      turn    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            Enable  <= {{(N-1){1'b0}}, 1'b1} << pick;
            Owner   <= pick;
            BusIdle <= 1'b0;
            hold    <= HW'(1);
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            Enable  <= '0;
            BusIdle <= 1'b1;
            ptr     <= next_ptr;
            turn    <= TW'(1);
            state   <= TURN;
          end else if (MAX_HOLD != 0) begin
            hold <= hold + 1'b1;
          end
        end
        TURN: begin
          if (turn != TURN_LIM) begin
            turn <= turn + 1'b1;
          end else if (found) begin
            Enable  <= {{(N-1){1'b0}}, 1'b1} << pick;
            Owner   <= pick;
            BusIdle <= 1'b0;
            hold    <= HW'(1);
            state   <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trisbus_arbiter.sv
// Bench for trisbus_arbiter: four instances with different parameter sets share
// one Reset/Req stimulus; each is compared every cycle against a tenure/gap
// model of the bus.
module tb_trisbus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] req = '0;

  logic [3:0] en_a, en_b, en_c;
  logic [4:0] en_d;
  logic [1:0] own_a, own_b, own_c;
  logic [2:0] own_d;
  logic       idle_a, idle_b, idle_c, idle_d;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  trisbus_arbiter #(.N(4), .MAX_HOLD(8), .TURN_CYCLES(1)) u_a (
    .Clock(clk), .Reset(rst), .Req(req[3:0]), .Enable(en_a), .Owner(own_a), .BusIdle(idle_a));
  trisbus_arbiter #(.N(4), .MAX_HOLD(8), .TURN_CYCLES(3)) u_b (
    .Clock(clk), .Reset(rst), .Req(req[3:0]), .Enable(en_b), .Owner(own_b), .BusIdle(idle_b));
  trisbus_arbiter #(.N(4), .MAX_HOLD(0), .TURN_CYCLES(1)) u_c (
    .Clock(clk), .Reset(rst), .Req(req[3:0]), .Enable(en_c), .Owner(own_c), .BusIdle(idle_c));
  trisbus_arbiter #(.N(5), .MAX_HOLD(3), .TURN_CYCLES(2)) u_d (
    .Clock(clk), .Reset(rst), .Req(req[4:0]), .Enable(en_d), .Owner(own_d), .BusIdle(idle_d));

  // Model parameters and state per instance: owner (-1 = bus free), cycles the
  // owner has held, consecutive all-zero cycles so far, next search start.
  int ns[4]   = '{4, 4, 4, 5};
  int mh[4]   = '{8, 8, 0, 3};
  int ts[4]   = '{1, 3, 1, 2};
  int m_own[4];
  int m_ten[4];
  int m_zero[4];
  int m_ptr[4];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned dut_en(input int i);
    case (i)
      0: return 32'(en_a);
      1: return 32'(en_b);
      2: return 32'(en_c);
      default: return 32'(en_d);
    endcase
  endfunction

  function automatic int unsigned dut_own(input int i);
    case (i)
      0: return 32'(own_a);
      1: return 32'(own_b);
      2: return 32'(own_c);
      default: return 32'(own_d);
    endcase
  endfunction

  function automatic int unsigned dut_idle(input int i);
    case (i)
      0: return 32'(idle_a);
      1: return 32'(idle_b);
      2: return 32'(idle_c);
      default: return 32'(idle_d);
    endcase
  endfunction

  task automatic model_step(input int i, input logic r, input logic [15:0] rq);
    int n;
    int o;
    n = ns[i];
    if (r) begin
      m_own[i]  = -1;
      m_ten[i]  = 0;
      m_zero[i] = ts[i];
      m_ptr[i]  = 0;
    end else if (m_own[i] >= 0) begin
      o = m_own[i];
      if (!rq[o] || (mh[i] != 0 && m_ten[i] == mh[i])) begin
        m_ptr[i]  = (o + 1) % n;
        m_own[i]  = -1;
        m_zero[i] = 1;
      end else begin
        m_ten[i]++;
      end
    end else if (m_zero[i] >= ts[i]) begin
      for (int k = 0; k < n; k++) begin
        int c;
        c = (m_ptr[i] + k) % n;
        if (m_own[i] < 0 && rq[c]) begin
          m_own[i] = c;
          m_ten[i] = 1;
        end
      end
    end else begin
      m_zero[i]++;
    end
  endtask

  task automatic compare_all();
    int unsigned e;
    for (int i = 0; i < 4; i++) begin
      e = (m_own[i] >= 0) ? (32'd1 << m_own[i]) : 32'd0;
      check($sformatf("enable%0d", i), dut_en(i), e);
      check($sformatf("busidle%0d", i), dut_idle(i), (e == 0) ? 1 : 0);
      check($sformatf("onehot%0d", i), ($countones(dut_en(i)) <= 1) ? 1 : 0, 1);
      if (m_own[i] >= 0)
        check($sformatf("owner%0d", i), dut_own(i), 32'(m_own[i]));
    end
  endtask

  // One clock: model sees the same Reset/Req the DUT samples, then compare.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 4; i++) model_step(i, rst, req);
    #1;
    compare_all();
  endtask

  task automatic run(input logic [15:0] r, input int cycles);
    req = r;
    for (int c = 0; c < cycles; c++) step();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_own[i] = -1; m_ten[i] = 0; m_zero[i] = ts[i]; m_ptr[i] = 0;
    end
    #1;
    // Reset for two cycles
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_en", 32'(en_a), 0);
    check("rst_idle", 32'(idle_a), 1);
    check("rst_owner", 32'(own_a), 0);

    // Single grant, one-cycle latency, release on drop
    req = 16'h0004;
    step();
    check("grant_en", 32'(en_a), 32'h4);
    check("grant_owner", 32'(own_a), 2);
    run(16'h0004, 3);
    run(16'h0000, 1);
    check("drop_en", 32'(en_a), 0);
    run(16'h0000, 4);

    // Round-robin fairness and hold limit
    run(16'h001f, 60);
    // Sole requester: release at limit and wrap back to itself
    run(16'h0001, 30);
    run(16'h0000, 4);

    // Turnaround: owner 1 drops while 3 is pending
    rst = 1'b1; step(); rst = 1'b0;
    run(16'h000a, 3);
    run(16'h0008, 8);

    // Reset mid-tenure, then grant from ptr 0
    run(16'h0002, 3);
    rst = 1'b1;
    step();
    check("midrst_en", 32'(en_a), 0);
    rst = 1'b0;
    req = 16'h000a;
    step();
    check("postrst_owner", 32'(own_a), 1);
    run(16'h000a, 4);

    // Unlimited hold on instance C while another requester waits
    rst = 1'b1; step(); rst = 1'b0;
    run(16'h0003, 100);
    check("unlim_en", 32'(en_c), 1);
    run(16'h0002, 3);
    check("unlim_next", 32'(en_c), 2);

    // Sub-cycle pulse while idle is never seen
    run(16'h0000, 6);
    for (int p = 0; p < 5; p++) begin
      #2 req = 16'h0001 << p;
      #2 req = 16'h0000;
      step();
      check("pulse_en", 32'(en_a), 0);
    end

    // Randomized: sticky requests with occasional flips and rare resets
    req = 16'(($urandom & 32'h1f));
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached got=running exp=finished");
    $fatal(1);
  end

endmodule
